dma_mch_fifo: RTL

- Multi-channel successor to the single-channel DMA FIFO; sits between the AHB master read path and the APB write path of the 4-channel DMA controller.
- Holds NUM_CH independent circular FIFOs in one storage array: one shared write port and one shared read port, each steered by a channel index.
- Adds per-channel occupancy level, almost-full flag and flush, plus optional sticky overflow/underflow error flags.

---
 rtl/dma_mch_fifo_if.sv | 49 ++++
 rtl/dma_mch_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dma_mch_fifo_if.sv
// -----------------------------------------------------------------------------
// dma_mch_fifo_if
// Bundles the write port, read port, per-channel control and per-channel status
// of the multi-channel DMA FIFO.
//   master : the DMA engine side (drives requests, flush, err_clr)
//   slave  : the FIFO itself (drives rd_data/rd_valid and all status vectors)
// Signals:
//   wr_en/wr_ch/wr_data        shared write port, steered by wr_ch
//   rd_en/rd_ch                shared read request, steered by rd_ch
//   rd_data/rd_valid           registered read result, one cycle after request
//   flush/err_clr              per-channel flush and sticky-error clear
//   full/empty/almost_full     per-channel occupancy flags
//   level                      packed per-channel occupancy (ADDR_WIDTH+1 each)
//   ovf_err/udf_err            per-channel sticky overflow/underflow flags
// -----------------------------------------------------------------------------
interface dma_mch_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int CH_WIDTH   = 2
);
  localparam int NUM_CH = 2 ** CH_WIDTH;
  localparam int LVL_W  = NUM_CH * (ADDR_WIDTH + 1);

  logic                  wr_en;
  logic [CH_WIDTH-1:0]   wr_ch;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [CH_WIDTH-1:0]   rd_ch;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [NUM_CH-1:0]     flush;
  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     empty;
  logic [NUM_CH-1:0]     almost_full;
  logic [LVL_W-1:0]      level;
  logic [NUM_CH-1:0]     err_clr;
  logic [NUM_CH-1:0]     ovf_err;
  logic [NUM_CH-1:0]     udf_err;

  modport master (
    output wr_en, wr_ch, wr_data, rd_en, rd_ch, flush, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, level, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, rd_en, rd_ch, flush, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, level, ovf_err, udf_err
  );
endinterface

// File: rtl/dma_mch_fifo.sv
// -----------------------------------------------------------------------------
// dma_mch_fifo
// NUM_CH independent circular FIFOs sharing one storage array, one write port
// and one read port. Each channel owns a wr/rd pointer pair with a wrap bit, so
// occupancy is simply wr_ptr - rd_ptr and full/empty need no extra state.
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   asynchronous active-high reset (storage array is not reset)
//   bus   dma_mch_fifo_if.slave, see the interface header for the signal list
// Optional build macro:
//   DMA_FIFO_ERR_EN  builds sticky per-channel overflow/underflow flags cleared
//                    by err_clr; when undefined the flags are tied to 0 and
//                    err_clr is ignored. The port list is the same either way.
// Read data is registered: an accepted read returns its word on the next edge
// with a one-cycle rd_valid pulse; rd_data holds otherwise.
// -----------------------------------------------------------------------------
module dma_mch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int CH_WIDTH   = 2,
  parameter int AF_THRESH  = 3
) (
  input logic           clk,
  input logic           rst,
  dma_mch_fifo_if.slave bus
);
  localparam int NUM_CH = 2 ** CH_WIDTH;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int PW     = ADDR_WIDTH + 1;
  localparam int MEM_AW = CH_WIDTH + ADDR_WIDTH;
  localparam int MEM_N  = 2 ** MEM_AW;

  localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL    = PW'(AF_THRESH);
  localparam logic [PW-1:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Storage and per-channel pointers
  logic [DATA_WIDTH-1:0] mem_r [MEM_N];
  logic [PW-1:0]         wr_ptr_r [NUM_CH];
  logic [PW-1:0]         rd_ptr_r [NUM_CH];
  logic [PW-1:0]         wr_ptr_nxt_s [NUM_CH];
  logic [PW-1:0]         rd_ptr_nxt_s [NUM_CH];

  // Decoded status
  logic [PW-1:0]           level_s [NUM_CH];
  logic [NUM_CH*PW-1:0]    level_pk_s;
  logic [NUM_CH-1:0]       full_s;
  logic [NUM_CH-1:0]       empty_s;
  logic [NUM_CH-1:0]       afull_s;

  // Request acceptance and addressing
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [MEM_AW-1:0]     wr_addr_s;
  logic [MEM_AW-1:0]     rd_addr_s;

  // Read result registers
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

  // Decode level/full/empty/almost_full from the registered pointers only
  always_comb begin
    level_pk_s = '0;
    full_s     = '0;
    empty_s    = '0;
    afull_s    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      level_s[c] = wr_ptr_r[c] - rd_ptr_r[c];
      level_pk_s[c*PW +: PW] = level_s[c];
      full_s[c]  = (level_s[c] == DEPTH_LVL);
      empty_s[c] = (level_s[c] == {PW{1'b0}});
      afull_s[c] = (level_s[c] >= AF_LVL);
    end
  end

  // Acceptance uses pre-edge flags, so a same-cycle pop never frees room for a
  // push to a full channel and a same-cycle push never feeds an empty read.
  assign wr_acc_s  = bus.wr_en & ~full_s[bus.wr_ch]  & ~bus.flush[bus.wr_ch];
  assign rd_acc_s  = bus.rd_en & ~empty_s[bus.rd_ch] & ~bus.flush[bus.rd_ch];
  assign wr_addr_s = {bus.wr_ch, wr_ptr_r[bus.wr_ch][ADDR_WIDTH-1:0]};
  assign rd_addr_s = {bus.rd_ch, rd_ptr_r[bus.rd_ch][ADDR_WIDTH-1:0]};

  // Next-pointer selection per channel; flush overrides any push/pop
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ptr_nxt_s[c] = wr_ptr_r[c];
      rd_ptr_nxt_s[c] = rd_ptr_r[c];
      if (bus.flush[c]) begin
        wr_ptr_nxt_s[c] = {PW{1'b0}};
        rd_ptr_nxt_s[c] = {PW{1'b0}};
      end else begin
        if (wr_acc_s && (bus.wr_ch == CH_WIDTH'(c))) begin
          wr_ptr_nxt_s[c] = wr_ptr_r[c] + PTR_ONE;
        end else begin
          wr_ptr_nxt_s[c] = wr_ptr_r[c];
        end
        if (rd_acc_s && (bus.rd_ch == CH_WIDTH'(c))) begin
          rd_ptr_nxt_s[c] = rd_ptr_r[c] + PTR_ONE;
        end else begin
          rd_ptr_nxt_s[c] = rd_ptr_r[c];
        end
      end
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_r[c] <= {PW{1'b0}};
        rd_ptr_r[c] <= {PW{1'b0}};
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_r[c] <= wr_ptr_nxt_s[c];
        rd_ptr_r[c] <= rd_ptr_nxt_s[c];
      end
    end
  end

  // Storage write; the array is deliberately left without reset
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_addr_s] <= bus.wr_data;
    end
  end

  // Registered read port: data and a one-cycle valid pulse per accepted pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_r <= mem_r[rd_addr_s];
      end
    end
  end

`ifdef DMA_FIFO_ERR_EN
  logic [NUM_CH-1:0] ovf_r;
  logic [NUM_CH-1:0] udf_r;
  logic [NUM_CH-1:0] ovf_set_s;
  logic [NUM_CH-1:0] udf_set_s;

  // Error events: request against a full/empty channel that is not flushing
  always_comb begin
    ovf_set_s = '0;
    udf_set_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ovf_set_s[c] = bus.wr_en && (bus.wr_ch == CH_WIDTH'(c)) && full_s[c]  && !bus.flush[c];
      udf_set_s[c] = bus.rd_en && (bus.rd_ch == CH_WIDTH'(c)) && empty_s[c] && !bus.flush[c];
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= {NUM_CH{1'b0}};
      udf_r <= {NUM_CH{1'b0}};
    end else begin
      ovf_r <= ovf_set_s | (ovf_r & ~bus.err_clr);
      udf_r <= udf_set_s | (udf_r & ~bus.err_clr);
    end
  end

  assign bus.ovf_err = ovf_r;
  assign bus.udf_err = udf_r;
`else
  logic err_clr_unused_s;

  assign err_clr_unused_s = ^bus.err_clr;
  assign bus.ovf_err      = {NUM_CH{1'b0}};
  assign bus.udf_err      = {NUM_CH{1'b0}};
`endif

  assign bus.rd_data     = rd_data_r;
  assign bus.rd_valid    = rd_valid_r;
  assign bus.full        = full_s;
  assign bus.empty       = empty_s;
  assign bus.almost_full = afull_s;
  assign bus.level       = level_pk_s;
endmodule
